mem_stage_dm: RTL and testbench
===============================

# mem_stage_dm

Data memory for the MEM stage of the five-stage MIPS pipeline. It consumes the store strobe from the MEM-stage control decoder (`sw`) plus the sibling `sh`/`sb`/load strobes, commits stores on the clock edge and returns sign- or zero-extended load data combinationally to the MEM/WB register. It also keeps a sticky misalignment flag and a store counter for the testbench and debug.

## Interface

Parameters:
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words (1024 words, 4 KiB).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 means in reset.
- `addr`  in  32  byte address from the EX/MEM ALU result.
- `wdata`  in  32  store data, already forwarded, from the rt value.
- `sw`  in  1  store word.
- `sh`  in  1  store halfword, using `wdata[15:0]`.
- `sb`  in  1  store byte, using `wdata[7:0]`.
- `lw`, `lh`, `lhu`, `lb`, `lbu`  in  1 each  load strobes.
- `rdata`  out  32  load result, extended.
- `align_err`  out  1  sticky misaligned-access flag.
- `store_cnt`  out  16  count of committed stores.

## Operation

- Word index is `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored and the address wraps modulo the memory size.
- Alignment rules:
  - Word access requires `addr[1:0]==0`.
  - Halfword access requires `addr[0]==0`.
  - Byte access is always aligned.
- Store strobe priority is `sw` > `sh` > `sb`. Only the highest asserted strobe acts.
- Aligned store byte enables:
  - `sw`: all four bytes.
  - `sh`: bytes {1,0} if `addr[1]==0`, else {3,2}.
  - `sb`: byte `addr[1:0]`.
  - Bytes not enabled keep their old value.
- A misaligned store is suppressed: memory is unchanged and `store_cnt` is not incremented.
- Load strobe priority is `lw` > `lh` > `lhu` > `lb` > `lbu`.
- Load data selection:
  - `lw` returns the whole word.
  - `lh` and `lhu` select the halfword by `addr[1]`.
  - `lb` and `lbu` select the byte by `addr[1:0]`.
  - `lh` and `lb` sign-extend; `lhu` and `lbu` zero-extend.
- `rdata` is 0 in these cases:
  - no load strobe is asserted;
  - the selected load is misaligned.
- A load and a store in the same cycle:
  - the load returns the pre-store contents;
  - the store commits at the edge.
- `align_err` is set at the edge after any misaligned access, load or store. It stays at 1 until reset.
- `store_cnt` increments by 1 per committed store and wraps from 0xFFFF to 0x0000.

## Timing

- Reset (`reset`=0, asynchronous):
  - all memory words clear to 0;
  - `align_err` clears to 0;
  - `store_cnt` clears to 0;
  - `rdata` reads 0 from memory, so it is 0 during reset.
- Reset asserted mid-operation overrides any store in that cycle; no partial write survives.
- Stores, `align_err` and `store_cnt` update on the first rising edge after deassertion, not during it.
- Store latency: the data is written at the rising edge of the cycle the strobe is presented. A load of the same address in the next cycle returns the new data.
- Load latency: zero cycles, purely combinational from `addr` and the load strobes. The MEM/WB register samples `rdata` at the same edge.
- There is no handshake and no stall. One access per cycle is always accepted.
- Strobes are assumed one-hot from the decoder. The priority rules define the behaviour when they are not.

## Test plan

- **Reset:** hold `reset`=0 with `sw`=1, `addr`=0x10, `wdata`=0xDEADBEEF. Then release and assert `lw` at 0x10. Required: `rdata`=0, `store_cnt`=0, `align_err`=0.
- **Word round trip:** `sw` 0x12345678 to 0x0 and 0xCAFEBABE to 0xFFC. Then `lw` each address. Required: matching data and `store_cnt`=2. Then `sw` to 0x1000 and `lw` 0x0. Required: the new value, showing the wrap, and `store_cnt`=3.
- **Sub-word merge:**
  - `sw` 0x11223344 to 0x20.
  - `sb` 0xAA to 0x21, then `sh` 0x8001 to 0x22.
  - `lw` 0x20 returns 0x8001AA44.
  - `lh` 0x22 returns 0xFFFF8001 and `lhu` 0x22 returns 0x00008001.
  - `lb` 0x21 returns 0xFFFFFFAA and `lbu` 0x21 returns 0x000000AA.
- **Misaligned store:** after the merge scenario, `sw` 0xFFFFFFFF to 0x22. Required: `lw` 0x20 still returns 0x8001AA44, `store_cnt` is unchanged, `align_err`=1 from the next edge and stays 1 across later aligned accesses.
- **Misaligned load:** `lh` at 0x21. Required: `rdata`=0 and `align_err`=1 after the edge.
- **Same-cycle load/store and counter wrap:**
  - With 0x5 stored at 0x40, assert `lw` and `sw` 0x6 to 0x40 in one cycle. Required: `rdata`=0x5 that cycle and 0x6 the next.
  - Issue 65536 aligned stores. Required: `store_cnt` returns to its starting value.

Source files
------------

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: byte-enabled stores committed on the clock edge and
// combinational, extended load data for the MEM/WB register.
module mem_stage_dm #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        sw,
    input  logic        sh,
    input  logic        sb,
    input  logic        lw,
    input  logic        lh,
    input  logic        lhu,
    input  logic        lb,
    input  logic        lbu,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic [15:0] store_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_r [DEPTH];
    logic                  align_err_r;
    logic [15:0]           store_cnt_r;
    logic [DEPTH_LOG2-1:0] widx_s;
    logic [31:0]           word_s;
    logic [15:0]           half_s;
    logic [7:0]            byte_s;
    logic [3:0]            be_s;
    logic [31:0]           wrep_s;
    logic                  st_req_s;
    logic                  st_mis_s;
    logic                  st_commit_s;
    logic                  ld_mis_s;
    logic [31:0]           rdata_s;
    logic                  unused_addr_s;

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Upper address bits are deliberately ignored so the address wraps.
    assign widx_s        = addr[DEPTH_LOG2+1:2];
    assign unused_addr_s = ^addr[31:DEPTH_LOG2+2];
    assign word_s        = mem_r[widx_s];

    // Store strobe priority, alignment check and byte-lane enable decode
    always_comb begin
        be_s     = 4'b0000;
        wrep_s   = wdata;
        st_req_s = 1'b0;
        st_mis_s = 1'b0;
        if (sw) begin
            st_req_s = 1'b1;
            st_mis_s = (addr[1:0] != 2'b00);
            be_s     = 4'b1111;
        end else if (sh) begin
            st_req_s = 1'b1;
            st_mis_s = addr[0];
            be_s     = addr[1] ? 4'b1100 : 4'b0011;
            wrep_s   = {2{wdata[15:0]}};
        end else if (sb) begin
            st_req_s = 1'b1;
            be_s     = 4'b0001 << addr[1:0];
            wrep_s   = {4{wdata[7:0]}};
        end else begin
            st_req_s = 1'b0;
        end
    end

    assign st_commit_s = st_req_s & ~st_mis_s;

    // Sub-word lane selection of the addressed word
    always_comb begin
        half_s = addr[1] ? word_s[31:16] : word_s[15:0];
        case (addr[1:0])
            2'd0:    byte_s = word_s[7:0];
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            2'd3:    byte_s = word_s[31:24];
            default: byte_s = word_s[7:0];
        endcase
    end

    // Load priority, alignment check and extension; misaligned loads read 0
    always_comb begin
        rdata_s  = 32'h0000_0000;
        ld_mis_s = 1'b0;
        if (lw) begin
            ld_mis_s = (addr[1:0] != 2'b00);
            rdata_s  = ld_mis_s ? 32'h0000_0000 : word_s;
        end else if (lh) begin
            ld_mis_s = addr[0];
            rdata_s  = ld_mis_s ? 32'h0000_0000 : ext16(half_s, 1'b1);
        end else if (lhu) begin
            ld_mis_s = addr[0];
            rdata_s  = ld_mis_s ? 32'h0000_0000 : ext16(half_s, 1'b0);
        end else if (lb) begin
            rdata_s  = ext8(byte_s, 1'b1);
        end else if (lbu) begin
            rdata_s  = ext8(byte_s, 1'b0);
        end else begin
            rdata_s  = 32'h0000_0000;
        end
    end

    // Memory array: full clear on reset, byte-lane merge on committed stores
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (st_commit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[widx_s][8*b +: 8] <= wrep_s[8*b +: 8];
                end
            end
        end
    end

    // Sticky misalignment flag and wrapping committed-store counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_err_r <= 1'b0;
            store_cnt_r <= 16'h0000;
        end else begin
            align_err_r <= align_err_r | (st_req_s & st_mis_s) | ld_mis_s;
            if (st_commit_s) begin
                store_cnt_r <= store_cnt_r + 16'd1;
            end
        end
    end

    assign rdata     = rdata_s;
    assign align_err = align_err_r;
    assign store_cnt = store_cnt_r;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Self-checking bench for mem_stage_dm: byte-array reference model, directed
// scenarios with literal expectations, randomized traffic and counter wrap.
module tb_mem_stage_dm;

    localparam logic [7:0] SW = 8'h80, SH = 8'h40, SB = 8'h20, LW = 8'h10;
    localparam logic [7:0] LH = 8'h08, LHU = 8'h04, LB = 8'h02, LBU = 8'h01, NONE = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        sw, sh, sb, lw, lh, lhu, lb, lbu;
    logic [31:0] rdata;
    logic        align_err;
    logic [15:0] store_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_mem [1024];
    logic        m_ae;
    logic [15:0] m_cnt;

    logic        check_en;
    logic        lit_rd_en, lit_cnt_en, lit_ae_en;
    logic [31:0] lit_rd;
    logic [15:0] lit_cnt;
    logic        lit_ae;

    always #5 clk = ~clk;

    mem_stage_dm dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .sw(sw), .sh(sh), .sb(sb), .lw(lw), .lh(lh), .lhu(lhu), .lb(lb), .lbu(lbu),
        .rdata(rdata), .align_err(align_err), .store_cnt(store_cnt)
    );

    // Access size in bytes of the winning strobe; 0 when none is asserted.
    function automatic int st_size(input logic [2:0] s);
        return s[2] ? 4 : s[1] ? 2 : s[0] ? 1 : 0;
    endfunction

    function automatic int ld_size(input logic [4:0] l);
        return l[4] ? 4 : (l[3] | l[2]) ? 2 : (l[1] | l[0]) ? 1 : 0;
    endfunction

    function automatic bit ld_signed(input logic [4:0] l);
        return l[4] ? 1'b0 : l[3] ? 1'b1 : l[2] ? 1'b0 : l[1];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [4:0] l);
        int sz;
        int off;
        logic [31:0] w, mask, v;
        sz  = ld_size(l);
        off = int'(a[1:0]);
        if (sz == 0) return 32'h0;
        if ((off % sz) != 0) return 32'h0;
        w    = m_mem[a[11:2]];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (w >> (8 * off)) & mask;
        if (ld_signed(l) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model of architectural state
    always @(posedge clk or negedge reset) begin
        int ssz, lsz, off;
        if (!reset) begin
            for (int i = 0; i < 1024; i++) m_mem[i] <= 32'h0;
            m_ae  <= 1'b0;
            m_cnt <= 16'h0;
        end else begin
            ssz = st_size({sw, sh, sb});
            lsz = ld_size({lw, lh, lhu, lb, lbu});
            off = int'(addr[1:0]);
            if (ssz != 0) begin
                if ((off % ssz) == 0) begin
                    for (int b = 0; b < ssz; b++)
                        m_mem[addr[11:2]][8*(off+b) +: 8] <= wdata[8*b +: 8];
                    m_cnt <= m_cnt + 16'd1;
                end else begin
                    m_ae <= 1'b1;
                end
            end
            if (lsz != 0 && (off % lsz) != 0) m_ae <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (addr=%h t=%0t)", nm, act, exp, addr, $time);
        end
    endtask

    // Compare process: DUT against model every cycle, plus pinned literals
    always @(negedge clk) begin
        if (check_en) begin
            chk("rdata", rdata, exp_rd(addr, {lw, lh, lhu, lb, lbu}));
            chk("align_err", {31'd0, align_err}, {31'd0, m_ae});
            chk("store_cnt", {16'd0, store_cnt}, {16'd0, m_cnt});
            if (lit_rd_en)  chk("lit_rdata", rdata, lit_rd);
            if (lit_cnt_en) chk("lit_store_cnt", {16'd0, store_cnt}, {16'd0, lit_cnt});
            if (lit_ae_en)  chk("lit_align_err", {31'd0, align_err}, {31'd0, lit_ae});
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                         input bit re, input logic [31:0] rv,
                         input bit ce, input logic [15:0] cv,
                         input bit ae, input logic av);
        addr = a;
        wdata = d;
        {sw, sh, sb, lw, lh, lhu, lb, lbu} = s;
        lit_rd_en = re;  lit_rd = rv;
        lit_cnt_en = ce; lit_cnt = cv;
        lit_ae_en = ae;  lit_ae = av;
        @(posedge clk);
        #1;
        lit_rd_en = 1'b0; lit_cnt_en = 1'b0; lit_ae_en = 1'b0;
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        drive(a, d, s, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        addr = a;
        wdata = d;
        {sw, sh, sb, lw, lh, lhu, lb, lbu} = s;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] cnt_start;
        logic [31:0] ra;
        logic [7:0]  rs;
        int          pick;
        check_en = 1'b0;
        lit_rd_en = 1'b0; lit_cnt_en = 1'b0; lit_ae_en = 1'b0;
        lit_rd = 32'h0; lit_cnt = 16'h0; lit_ae = 1'b0;
        reset = 1'b0;
        addr = 32'h10; wdata = 32'hDEAD_BEEF;
        {sw, sh, sb, lw, lh, lhu, lb, lbu} = SW | LW;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(32'h10, 32'h0, LW, 1'b1, 32'h0, 1'b1, 16'd0, 1'b1, 1'b0);

        // Word round trip and address wrap
        go(32'h0, 32'h1234_5678, SW);
        go(32'hFFC, 32'hCAFE_BABE, SW);
        drive(32'h0, 32'h0, LW, 1'b1, 32'h1234_5678, 1'b1, 16'd2, 1'b0, 1'b0);
        drive(32'hFFC, 32'h0, LW, 1'b1, 32'hCAFE_BABE, 1'b0, 16'd0, 1'b0, 1'b0);
        go(32'h1000, 32'hA5A5_0001, SW);
        drive(32'h0, 32'h0, LW, 1'b1, 32'hA5A5_0001, 1'b1, 16'd3, 1'b0, 1'b0);

        // Sub-word merge and extension
        go(32'h20, 32'h1122_3344, SW);
        go(32'h21, 32'h0000_00AA, SB);
        go(32'h22, 32'h0000_8001, SH);
        drive(32'h20, 32'h0, LW,  1'b1, 32'h8001_AA44, 1'b1, 16'd6, 1'b0, 1'b0);
        drive(32'h22, 32'h0, LH,  1'b1, 32'hFFFF_8001, 1'b0, 16'd0, 1'b0, 1'b0);
        drive(32'h22, 32'h0, LHU, 1'b1, 32'h0000_8001, 1'b0, 16'd0, 1'b0, 1'b0);
        drive(32'h21, 32'h0, LB,  1'b1, 32'hFFFF_FFAA, 1'b0, 16'd0, 1'b0, 1'b0);
        drive(32'h21, 32'h0, LBU, 1'b1, 32'h0000_00AA, 1'b0, 16'd0, 1'b1, 1'b0);

        // Misaligned store is suppressed, flag sticks
        drive(32'h22, 32'hFFFF_FFFF, SW, 1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 1'b0);
        drive(32'h20, 32'h0, LW, 1'b1, 32'h8001_AA44, 1'b1, 16'd6, 1'b1, 1'b1);
        go(32'h30, 32'h0000_0123, SW);
        drive(32'h30, 32'h0, LW, 1'b1, 32'h0000_0123, 1'b1, 16'd7, 1'b1, 1'b1);

        // Mid-operation reset with a pending store, then misaligned load
        reset_pulse(32'h40, 32'h0000_0077, SW);
        drive(32'h40, 32'h0, LW, 1'b1, 32'h0, 1'b1, 16'd0, 1'b1, 1'b0);
        drive(32'h21, 32'h0, LH, 1'b1, 32'h0, 1'b0, 16'd0, 1'b1, 1'b0);
        drive(32'h0, 32'h0, NONE, 1'b1, 32'h0, 1'b0, 16'd0, 1'b1, 1'b1);

        // Same-cycle load and store
        reset_pulse(32'h0, 32'h0, NONE);
        go(32'h40, 32'h5, SW);
        drive(32'h40, 32'h6, SW | LW, 1'b1, 32'h5, 1'b0, 16'd0, 1'b0, 1'b0);
        drive(32'h40, 32'h0, LW, 1'b1, 32'h6, 1'b1, 16'd2, 1'b1, 1'b0);

        // Randomized traffic with periodic resets
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 249) reset_pulse($urandom(), $urandom(), 8'($urandom()));
            ra = $urandom() & 32'hFFFF_F03F;
            pick = int'($urandom_range(0, 9));
            if (pick < 8) rs = 8'h01 << pick;
            else if (pick == 8) rs = 8'($urandom());
            else rs = NONE;
            if ($urandom_range(0, 3) != 0) ra = ra & ~32'h3;
            go(ra, $urandom(), rs);
        end

        // Store counter wrap
        cnt_start = m_cnt;
        for (int i = 0; i < 65536; i++) go(32'h100 + ((32'(i) & 32'hF) << 2), $urandom(), SW);
        drive(32'h0, 32'h0, NONE, 1'b0, 32'h0, 1'b1, cnt_start, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
